fft_stage_seq: RTL
==================

FFT_STAGE_SEQ -- requirements
Module: fft_stage_seq

Interface
REQ-001 SHALL have parameter DELAY, default 24: butterfly delay-line depth in samples (fill latency).
REQ-002 SHALL have parameter SW_PERIOD, default 24: valid samples between butterfly switch toggles.
REQ-003 SHALL have parameter N, default 32: twiddle coefficients per frame.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, a sample pair enters the stage this cycle.
REQ-007 SHALL have port flush, input, 1, end of stream; drain the delay lines.
REQ-008 SHALL have port sw_ctrl, output, 1, butterfly (Blq) switch control.
REQ-009 SHALL have port coeff_en, output, 1, coefficient generator enable (ROM held in reset when low).
REQ-010 SHALL have port coeff_addr, output, clog2(N), twiddle index.
REQ-011 SHALL have port out_valid, output, 1, stage output sample pair valid.
REQ-012 SHALL have port frame_start, output, 1, one-cycle pulse on the first output of each coefficient frame.
REQ-013 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, FILL, RUN, DRAIN, all registered.
REQ-015 IDLE->FILL on in_valid; that sample SHALL count as fill sample 1.
REQ-016 FILL SHALL count in_valid cycles only; on fill sample DELAY -> RUN; cycles with in_valid low SHALL hold all counters.
REQ-017 In RUN, coeff_en SHALL be 1; out_valid SHALL equal in_valid delayed one cycle.
REQ-018 In RUN, each in_valid cycle SHALL increment sw_cnt modulo SW_PERIOD; on wrap to 0, sw_ctrl SHALL toggle in the same registered update.
REQ-019 In RUN, each out_valid cycle SHALL advance coeff_addr modulo N; wrap N-1->0 is silent, with no stall.
REQ-020 frame_start SHALL be 1 exactly when out_valid=1 and coeff_addr=0.
REQ-021 flush in FILL or RUN SHALL go to DRAIN next cycle; flush in IDLE or DRAIN SHALL be ignored.
REQ-022 DRAIN SHALL free-run exactly DELAY cycles, ignoring in_valid, with out_valid=1 and coeff/switch counters advancing as in RUN; it then SHALL go to IDLE.
REQ-023 flush and in_valid in the same cycle SHALL consume that sample first, then enter DRAIN.
REQ-024 Entering IDLE SHALL clear sw_cnt, coeff_addr and sw_ctrl, and deassert coeff_en and out_valid.
REQ-025 coeff_en SHALL be 1 only in RUN and DRAIN.

Reset
REQ-026 While rst=1, the next edge SHALL force IDLE with all outputs 0 and all counters 0, regardless of state.
REQ-027 rst mid-RUN or mid-DRAIN SHALL abort with no residual out_valid pulse after reset releases.
REQ-028 The first in_valid accepted SHALL be the one in the first cycle with rst=0.

Structure
REQ-029 The FSM state encoding and a CLOG2 helper SHALL live in the shared package fft_pkg.
REQ-030 One sub-module, mod_counter (parameter MOD, inc, clr, count, wrap), SHALL be instantiated for fill, switch, coefficient and drain counting.

Verification
REQ-031 rst, then in_valid held high (defaults) -> busy at cycle 1, coeff_en rises after sample 24, first out_valid one cycle later with frame_start=1 and coeff_addr=0.
REQ-032 Continuous RUN -> sw_ctrl toggles every 24 valid samples; coeff_addr goes 31->0 with frame_start every 32 outputs.
REQ-033 in_valid low for 5 cycles in FILL and in RUN -> counters frozen, no out_valid during the gap, sequence resumes unchanged.
REQ-034 flush asserted with in_valid at RUN sample 40 -> exactly 24 DRAIN out_valid cycles follow, then IDLE with busy=0 and sw_ctrl=0.
REQ-035 rst pulsed for one cycle mid-RUN with coeff_addr=17 -> next cycle all outputs 0, state IDLE, no out_valid afterwards.
REQ-036 flush in IDLE -> no state change; DELAY=4, SW_PERIOD=2, N=8 rerun of REQ-031 and REQ-032 with scaled values.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT stage sequencer.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/fft_stage_seq_mod_counter.sv
// Modulo-MOD event counter; wrap flags the increment that returns the count to zero.
module mod_counter
  import fft_pkg::*;
#(
  parameter int MOD = 2,
  localparam int W = clog2(MOD)
) (
  input  logic         clk,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] count_reg;

  assign wrap  = inc && (count_reg == LAST);
  assign count = count_reg;

  always_ff @(posedge clk) begin
    if (clr) begin
      count_reg <= '0;
    end else if (inc) begin
      count_reg <= wrap ? '0 : count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/fft_stage_seq.sv
// Control sequencer for one pipelined FFT stage: delay-line fill, butterfly switch,
// twiddle address generation and end-of-stream drain.
module fft_stage_seq
  import fft_pkg::*;
#(
  parameter int DELAY     = 24,
  parameter int SW_PERIOD = 24,
  parameter int N         = 32,
  localparam int AW = clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          flush,
  output logic          sw_ctrl,
  output logic          coeff_en,
  output logic [AW-1:0] coeff_addr,
  output logic          out_valid,
  output logic          frame_start,
  output logic          busy
);

  localparam int DW = clog2(DELAY);
  localparam int SWW = clog2(SW_PERIOD);

  state_t state_reg, state_next;
  logic   valid_d_reg;
  logic   sw_ctrl_reg;

  logic           fill_inc, fill_clr, fill_wrap;
  logic           sw_inc, sw_clr, sw_wrap;
  logic           coeff_inc, coeff_clr, coeff_wrap;
  logic           drain_inc, drain_clr, drain_wrap;
  logic [DW-1:0]  fill_count, drain_count;
  logic [SWW-1:0] sw_count;
  logic           in_run, in_drain, leaving_drain;
  logic           unused_counts;

  assign in_run        = (state_reg == RUN);
  assign in_drain      = (state_reg == DRAIN);
  assign leaving_drain = in_drain && drain_wrap;

  // A drain cycle stands in for a valid sample, so outputs and counters keep moving.
  assign out_valid = (in_run && valid_d_reg) || in_drain;

  assign fill_inc  = in_valid && ((state_reg == IDLE) || (state_reg == FILL));
  assign fill_clr  = rst || in_run || in_drain;
  assign sw_inc    = (in_run && in_valid) || in_drain;
  assign sw_clr    = rst || leaving_drain;
  assign coeff_inc = out_valid;
  assign coeff_clr = rst || leaving_drain;
  assign drain_inc = in_drain;
  assign drain_clr = rst;

  mod_counter #(.MOD(DELAY)) u_fill_cnt (
    .clk(clk), .inc(fill_inc), .clr(fill_clr), .count(fill_count), .wrap(fill_wrap)
  );

  mod_counter #(.MOD(SW_PERIOD)) u_sw_cnt (
    .clk(clk), .inc(sw_inc), .clr(sw_clr), .count(sw_count), .wrap(sw_wrap)
  );

  mod_counter #(.MOD(N)) u_coeff_cnt (
    .clk(clk), .inc(coeff_inc), .clr(coeff_clr), .count(coeff_addr), .wrap(coeff_wrap)
  );

  mod_counter #(.MOD(DELAY)) u_drain_cnt (
    .clk(clk), .inc(drain_inc), .clr(drain_clr), .count(drain_count), .wrap(drain_wrap)
  );

  assign unused_counts = ^{fill_count, drain_count, sw_count, coeff_wrap};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = fill_wrap ? RUN : FILL;
      FILL: begin
        if (flush)          state_next = DRAIN;
        else if (fill_wrap) state_next = RUN;
      end
      RUN:     if (flush) state_next = DRAIN;
      DRAIN:   if (drain_wrap) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      valid_d_reg <= 1'b0;
      sw_ctrl_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      valid_d_reg <= in_run && in_valid;
      if (leaving_drain) begin
        sw_ctrl_reg <= 1'b0;
      end else if (sw_wrap) begin
        sw_ctrl_reg <= ~sw_ctrl_reg;
      end
    end
  end

  assign sw_ctrl     = sw_ctrl_reg;
  assign coeff_en    = in_run || in_drain;
  assign busy        = (state_reg != IDLE);
  assign frame_start = out_valid && (coeff_addr == '0);

endmodule
